// File: rtl/inmp441_pkg.sv
// Shared constants and types for the INMP441 I2S capture front end.
package inmp441_pkg;

  localparam int W_SAMPLE   = 24;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  // Slot bit positions carrying sample data; bit 0 is the I2S one-bit delay.
  localparam logic [4:0] FIRST_DATA_BIT = 5'd1;
  localparam logic [4:0] LAST_DATA_BIT  = 5'd24;

  typedef logic signed [W_SAMPLE-1:0] mic_sample_t;

  // True when the SCK period indexed by bc carries a data bit of the chosen slot.
  function automatic logic in_capture_window(input logic [BIT_CNT_W-1:0] bc,
                                             input logic                 chan);
    return (bc[BIT_CNT_W-1] == chan) &&
           (bc[4:0] >= FIRST_DATA_BIT) && (bc[4:0] <= LAST_DATA_BIT);
  endfunction

endpackage

// File: rtl/inmp441_i2s_capture_sck_gen.sv
// SCK / WS generator: half-period divider, SCK toggle, 64-bit frame counter.
module i2s_sck_gen
  import inmp441_pkg::*;
#(
  parameter int SCK_HALF_DIV = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 sck_o,
  output logic                 ws_o,
  output logic                 sample_evt_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o
);

  localparam int DIV_W = (SCK_HALF_DIV > 1) ? $clog2(SCK_HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(SCK_HALF_DIV - 1);

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 sck_q, sck_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 ws_q, ws_d;
  logic                 terminal;
  logic                 fall_evt;

  // Next-state: divider wraps at terminal count, SCK toggles there, the frame
  // counter advances on the falling-edge event. WS takes the next counter MSB
  // so it changes in the same cycle as the SCK falling edge.
  always_comb begin
    terminal  = (div_cnt_q == DIV_TERM);
    fall_evt  = terminal && sck_q;
    div_cnt_d = terminal ? '0 : div_cnt_q + 1'b1;
    sck_d     = sck_q ^ terminal;
    bit_cnt_d = fall_evt ? bit_cnt_q + 1'b1 : bit_cnt_q;
    ws_d      = bit_cnt_d[BIT_CNT_W-1];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      bit_cnt_q <= '0;
      ws_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      bit_cnt_q <= bit_cnt_d;
      ws_q      <= ws_d;
    end
  end

  assign sck_o        = sck_q;
  assign ws_o         = ws_q;
  assign sample_evt_o = fall_evt;
  assign bit_cnt_o    = bit_cnt_q;

endmodule

// File: rtl/inmp441_i2s_capture.sv
// INMP441 capture: synchronizes sd, shifts the selected slot MSB first and
// publishes each 24-bit sample with a one-cycle write strobe.
//
// Output protocol: value_we is a pure strobe with no back-pressure. value
// changes only in the cycle value_we is 1 and holds until the next strobe.
module inmp441_i2s_capture
  import inmp441_pkg::*;
#(
  parameter int SCK_HALF_DIV = 10,
  parameter int CHANNEL      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                sck,
  output logic                ws,
  output logic                lr,
  input  logic                sd,
  output logic [W_SAMPLE-1:0] value,
  output logic                value_we
);

  localparam logic CH_SEL = (CHANNEL != 0);

  logic                 sample_evt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [1:0]           sync_q, sync_d;
  logic [W_SAMPLE-1:0]  shift_q, shift_d;
  mic_sample_t          value_q, value_d;
  logic                 we_q, we_d;
  logic                 capture;
  logic                 last_bit;
  logic                 sd_s;

  i2s_sck_gen #(
    .SCK_HALF_DIV(SCK_HALF_DIV)
  ) u_sck_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .sck_o       (sck),
    .ws_o        (ws),
    .sample_evt_o(sample_evt),
    .bit_cnt_o   (bit_cnt)
  );

  // Next-state: bits are taken at the end of each SCK high phase when inside
  // the selected slot's data window; the 24th bit completes the sample.
  always_comb begin
    sync_d   = {sync_q[0], sd};
    sd_s     = sync_q[1];
    capture  = sample_evt && in_capture_window(bit_cnt, CH_SEL);
    last_bit = capture && (bit_cnt[4:0] == LAST_DATA_BIT);
    shift_d  = capture ? {shift_q[W_SAMPLE-2:0], sd_s} : shift_q;
    value_d  = last_bit ? mic_sample_t'({shift_q[W_SAMPLE-2:0], sd_s}) : value_q;
    we_d     = last_bit;
  end

  // Synchronizer, shift register and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      shift_q <= '0;
      value_q <= '0;
      we_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      shift_q <= shift_d;
      value_q <= value_d;
      we_q    <= we_d;
    end
  end

  assign value    = value_q;
  assign value_we = we_q;
  assign lr       = CH_SEL;

endmodule
